// File: rtl/data_mem_dma_if.sv
// Data memory port bundle shared by the DMA engine and the memory.
// The DMA drives address/enable/write data; read data comes back combinationally.
interface data_mem_dma_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] Mem_Address;
  logic              Mem_En;
  logic [DATA_W-1:0] Mem_Data_in;
  logic [DATA_W-1:0] Mem_Data_out;

  modport master (
    output Mem_Address,
    output Mem_En,
    output Mem_Data_in,
    input  Mem_Data_out
  );

  modport slave (
    input  Mem_Address,
    input  Mem_En,
    input  Mem_Data_in,
    output Mem_Data_out
  );
endinterface

// File: rtl/data_mem_dma.sv
// Byte-serial block copy engine for the 32x8 data memory.
// Optional DATA_MEM_DMA_FILL_EN adds a 1-cycle-per-byte fill mode.
module data_mem_dma #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Src_addr,
  input  logic [ADDR_W-1:0] Dst_addr,
  input  logic [ADDR_W:0]   Len,
`ifdef DATA_MEM_DMA_FILL_EN
  input  logic              Fill,
  input  logic [DATA_W-1:0] Fill_data,
`endif
  output logic              Busy,
  output logic              Done,
  data_mem_dma_if.master    mem
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  localparam logic [ADDR_W:0] MAX_CNT =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT =
    (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W:0]   len_clamp;
  logic              fill_in;
  logic              fill_q;
  logic [DATA_W-1:0] wdata_src;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic [DATA_W-1:0] wdata;

`ifdef DATA_MEM_DMA_FILL_EN
  logic              fill_d;
  logic [DATA_W-1:0] fdat_q, fdat_d;

  assign fill_in   = Fill;
  assign wdata_src = fill_q ? fdat_q : buf_q;

  always_comb begin
    fill_d = fill_q;
    fdat_d = fdat_q;
    if (state_q == IDLE && Start) begin
      fill_d = Fill;
      fdat_d = Fill_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fill_q <= 1'b0;
      fdat_q <= '0;
    end else begin
      fill_q <= fill_d;
      fdat_q <= fdat_d;
    end
  end
`else
  assign fill_in   = 1'b0;
  assign fill_q    = 1'b0;
  assign wdata_src = buf_q;
`endif

  assign len_clamp = (Len > MAX_CNT) ? MAX_CNT : Len;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    Busy    = 1'b0;
    Done    = 1'b0;
    addr    = '0;
    en      = 1'b0;
    wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          src_d = Src_addr;
          dst_d = Dst_addr;
          cnt_d = len_clamp;
          if (len_clamp == '0)
            state_d = DONE;
          else if (fill_in)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        Busy    = 1'b1;
        addr    = src_q;
        buf_d   = mem.Mem_Data_out;
        src_d   = src_q + ADDR_W'(1);
        state_d = WRITE;
      end
      WRITE: begin
        Busy  = 1'b1;
        addr  = dst_q;
        en    = 1'b1;
        wdata = wdata_src;
        dst_d = dst_q + ADDR_W'(1);
        cnt_d = cnt_q - ONE_CNT;
        if (cnt_q == ONE_CNT)
          state_d = DONE;
        else if (fill_q)
          state_d = WRITE;
        else
          state_d = READ;
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset in a WRITE cycle must keep the in-flight byte out of memory
  assign mem.Mem_En      = en & ~Reset;
  assign mem.Mem_Address = addr;
  assign mem.Mem_Data_in = wdata;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_data_mem_dma.sv
// Directed bench for data_mem_dma with a behavioural 32x8 memory.
// Cycle 0 is the cycle in which Start is sampled high.
module tb_data_mem_dma;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [4:0] Src_addr;
  logic [4:0] Dst_addr;
  logic [5:0] Len;
  logic       Busy;
  logic       Done;
`ifdef DATA_MEM_DMA_FILL_EN
  logic       Fill;
  logic [7:0] Fill_data;
`endif

  data_mem_dma_if #(.ADDR_W(5), .DATA_W(8)) mif ();

  data_mem_dma #(.ADDR_W(5), .DATA_W(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Src_addr (Src_addr),
    .Dst_addr (Dst_addr),
    .Len      (Len),
`ifdef DATA_MEM_DMA_FILL_EN
    .Fill     (Fill),
    .Fill_data(Fill_data),
`endif
    .Busy     (Busy),
    .Done     (Done),
    .mem      (mif)
  );

  always #5 Clk = ~Clk;

  logic [7:0] mem [32];
  logic [7:0] img [32];
  logic       load = 1'b0;

  assign mif.Mem_Data_out = mem[mif.Mem_Address];

  always @(posedge Clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= img[i];
    end else if (mif.Mem_En) begin
      mem[mif.Mem_Address] <= mif.Mem_Data_in;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm,
                     input longint got,
                     input longint exp);
    total++;
    if (got == exp)
      passed++;
    else
      $display("FAIL %s: got %0h required %0h",
               nm, got, exp);
  endtask

  task automatic img_default();
    for (int i = 0; i < 32; i++)
      img[i] = 8'(8'h80 + i);
  endtask

  task automatic load_mem();
    @(negedge Clk);
    load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
  endtask

  task automatic run_cmd(
    input  logic [4:0]   s,
    input  logic [4:0]   d,
    input  logic [5:0]   l,
    input  int           alt_cyc,
    input  logic [4:0]   alt_dst,
    input  int           rst_cyc,
    output int           writes,
    output int           done_cyc,
    output int           busy_n,
    output int           done_n,
    output logic [127:0] en_mask,
    output logic [127:0] busy_mask,
    output int           clean
  );
    writes    = 0;
    done_cyc  = -1;
    busy_n    = 0;
    done_n    = 0;
    en_mask   = '0;
    busy_mask = '0;
    clean     = 1;
    @(negedge Clk);
    Start    = 1'b1;
    Src_addr = s;
    Dst_addr = d;
    Len      = l;
    for (int c = 1; c <= 120; c++) begin
      @(negedge Clk);
      Start = 1'b0;
      Reset = 1'b0;
      if (c == alt_cyc) begin
        Start    = 1'b1;
        Dst_addr = alt_dst;
      end
      if (c == rst_cyc)
        Reset = 1'b1;
      #1;
      if (mif.Mem_En) begin
        writes++;
        en_mask[c] = 1'b1;
      end
      if (Busy) begin
        busy_n++;
        busy_mask[c] = 1'b1;
      end
      if (Done) begin
        done_n++;
        if (done_cyc < 0)
          done_cyc = c;
      end
      if (!Busy && (mif.Mem_En ||
          mif.Mem_Address != '0 ||
          mif.Mem_Data_in != '0))
        clean = 0;
      if (done_cyc >= 0 && c >= done_cyc + 2)
        break;
      if (rst_cyc >= 0 && c >= rst_cyc + 3)
        break;
    end
    Start = 1'b0;
    Reset = 1'b0;
  endtask

  typedef struct {
    logic [4:0] src;
    logic [4:0] dst;
    logic [5:0] len;
    int         writes;
    int         done_cyc;
    logic [4:0] ca;
    logic [7:0] cv;
  } vec_t;

  initial begin
    vec_t         vt [7];
    int           wr, dc, bn, dn, cl;
    logic [127:0] em, bm;

    // memory preloaded with 0x80+addr before each vector
    vt[0] = '{5'd2,  5'd10, 6'd3,  3,  7,  5'd12, 8'h84};
    vt[1] = '{5'd0,  5'd5,  6'd0,  0,  1,  5'd5,  8'h85};
    vt[2] = '{5'd7,  5'd20, 6'd1,  1,  3,  5'd20, 8'h87};
    vt[3] = '{5'd30, 5'd31, 6'd3,  3,  7,  5'd1,  8'h9E};
    vt[4] = '{5'd0,  5'd1,  6'd40, 32, 65, 5'd0,  8'h80};
    vt[5] = '{5'd5,  5'd5,  6'd32, 32, 65, 5'd4,  8'h84};
    vt[6] = '{5'd16, 5'd0,  6'd63, 32, 65, 5'd0,  8'h90};

    Reset    = 1'b1;
    Start    = 1'b0;
    Src_addr = '0;
    Dst_addr = '0;
    Len      = '0;
`ifdef DATA_MEM_DMA_FILL_EN
    Fill      = 1'b0;
    Fill_data = '0;
`endif
    img_default();
    repeat (3) @(negedge Clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_en",   mif.Mem_En, 0);
    chk("rst_addr", mif.Mem_Address, 0);
    chk("rst_wdat", mif.Mem_Data_in, 0);
    Reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      img_default();
      load_mem();
      run_cmd(vt[i].src, vt[i].dst, vt[i].len,
              -1, 5'd0, -1,
              wr, dc, bn, dn, em, bm, cl);
      chk($sformatf("v%0d_writes", i), wr, vt[i].writes);
      chk($sformatf("v%0d_done", i), dc, vt[i].done_cyc);
      chk($sformatf("v%0d_busy", i), bn, 2 * vt[i].writes);
      chk($sformatf("v%0d_npulse", i), dn, 1);
      chk($sformatf("v%0d_idle0", i), cl, 1);
      chk($sformatf("v%0d_mem", i), mem[vt[i].ca], vt[i].cv);
    end

    // basic copy with exact cycle masks
    img_default();
    img[2] = 8'h11;
    img[3] = 8'h22;
    img[4] = 8'h33;
    load_mem();
    run_cmd(5'd2, 5'd10, 6'd3, -1, 5'd0, -1,
            wr, dc, bn, dn, em, bm, cl);
    chk("basic_enmask", em[31:0], 32'h0000_0054);
    chk("basic_busymask", bm[31:0], 32'h0000_007E);
    chk("basic_done", dc, 7);
    chk("basic_m10", mem[10], 8'h11);
    chk("basic_m11", mem[11], 8'h22);
    chk("basic_m12", mem[12], 8'h33);
    chk("basic_m13", mem[13], 8'h8D);

    // second Start while busy is ignored
    img_default();
    load_mem();
    run_cmd(5'd2, 5'd10, 6'd3, 3, 5'd20, -1,
            wr, dc, bn, dn, em, bm, cl);
    chk("restart_writes", wr, 3);
    chk("restart_done", dc, 7);
    chk("restart_m12", mem[12], 8'h84);
    chk("restart_m20", mem[20], 8'h94);

    // reset during the second write
    img_default();
    load_mem();
    run_cmd(5'd2, 5'd10, 6'd5, -1, 5'd0, 4,
            wr, dc, bn, dn, em, bm, cl);
    chk("abort_writes", wr, 1);
    chk("abort_npulse", dn, 0);
    chk("abort_busy", bn, 4);
    chk("abort_idle0", cl, 1);
    chk("abort_m10", mem[10], 8'h82);
    chk("abort_m11", mem[11], 8'h8B);

    // engine recovers after abort
    run_cmd(5'd0, 5'd30, 6'd1, -1, 5'd0, -1,
            wr, dc, bn, dn, em, bm, cl);
    chk("recover_done", dc, 3);
    chk("recover_m30", mem[30], 8'h80);

`ifdef DATA_MEM_DMA_FILL_EN
    img_default();
    load_mem();
    Fill      = 1'b1;
    Fill_data = 8'hA5;
    run_cmd(5'd0, 5'd5, 6'd4, -1, 5'd0, -1,
            wr, dc, bn, dn, em, bm, cl);
    Fill      = 1'b0;
    chk("fill_enmask", em[31:0], 32'h0000_001E);
    chk("fill_done", dc, 5);
    chk("fill_m5", mem[5], 8'hA5);
    chk("fill_m8", mem[8], 8'hA5);
    chk("fill_m9", mem[9], 8'h89);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
